// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED chase sequencer: FSM state encoding,
// direction encoding, datapath widths and chaser rotation helpers.
package led_seq_pkg;

    localparam int DUTY_W = 6;
    localparam int LED_N  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_FWD = 2'd1,
        ST_RUN_REV = 2'd2,
        ST_PAUSE   = 2'd3
    } state_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    function automatic logic [LED_N-1:0] rot_left(input logic [LED_N-1:0] v);
        return {v[LED_N-2:0], v[LED_N-1]};
    endfunction

    function automatic logic [LED_N-1:0] rot_right(input logic [LED_N-1:0] v);
        return {v[0], v[LED_N-1:1]};
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-FF synchronizer -> optional debounce (DEBOUNCE_EN) -> one-cycle
// rising-edge pulse.
module btn_conditioner
    import led_seq_pkg::*;
`ifdef DEBOUNCE_EN
#(
    parameter int DEB_W = 16
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic cond;
    logic cond_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            cond_prev <= 1'b0;
        end else begin
            sync_p0   <= btn;
            sync_p1   <= sync_p0;
            cond_prev <= cond;
        end
    end

`ifdef DEBOUNCE_EN
    // Flip on the cycle the count reaches all-ones minus one, so the level has
    // then differed for exactly 2^DEB_W - 1 cycles.
    localparam logic [DEB_W-1:0] DEB_LAST = {{(DEB_W-1){1'b1}}, 1'b0};
    localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

    logic [DEB_W-1:0] deb_cnt;
    logic             cond_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            cond_q  <= 1'b0;
        end else if (sync_p1 == cond_q) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            cond_q  <= sync_p1;
        end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
        end
    end

    assign cond = cond_q;
`else
    assign cond = sync_p1;
`endif

    assign pulse = cond & ~cond_prev;

endmodule

// File: rtl/led_chase_sequencer.sv
// LED chase sequencer: prescaler, PWM triangle ramp, one-hot chaser and the
// run/pause/direction FSM. Define DEBOUNCE_EN to debounce the buttons.
module led_chase_sequencer
    import led_seq_pkg::*;
#(
    parameter int                DIV_W    = 22,
    parameter logic [DUTY_W-1:0] DUTY_MIN = 6'd0,
    parameter logic [DUTY_W-1:0] DUTY_MAX = 6'd63,
    parameter int                DEB_W    = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_run,
    input  logic              btn_dir,
    output logic [LED_N-1:0]  led_drive,
    output logic [LED_N-1:0]  led_onehot,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        state,
    output logic              step_tick
);

    localparam logic [DIV_W-1:0]  PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DUTY_W-1:0] DUTY_ONE  = {{(DUTY_W-1){1'b0}}, 1'b1};
    localparam logic [LED_N-1:0]  LED_FIRST = {{(LED_N-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0]  presc;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              run_ev;
    logic              dir_ev;
    logic              chase_ev;

    state_t            st_q, st_d;
    logic [LED_N-1:0]  led_q, led_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              ramp_up_q, ramp_up_d;
    dir_t              saved_dir_q, saved_dir_d;

    btn_conditioner
`ifdef DEBOUNCE_EN
        #(.DEB_W(DEB_W))
`endif
        u_run_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .pulse (run_ev)
    );

    btn_conditioner
`ifdef DEBOUNCE_EN
        #(.DEB_W(DEB_W))
`endif
        u_dir_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_dir),
        .pulse (dir_ev)
    );

    assign step_tick  = &presc;
    assign pwm_out    = (st_q != ST_IDLE) && (pwm_cnt <= duty_q);
    assign led_drive  = led_q & {LED_N{pwm_out}};
    assign led_onehot = led_q;
    assign duty       = duty_q;
    assign state      = st_q;

    always_comb begin
        st_d        = st_q;
        led_d       = led_q;
        duty_d      = duty_q;
        ramp_up_d   = ramp_up_q;
        saved_dir_d = saved_dir_q;
        chase_ev    = 1'b0;

        // Ramp sees the pre-transition state, so a coinciding tick uses the old mode.
        if (step_tick && (st_q == ST_RUN_FWD || st_q == ST_RUN_REV)) begin
            if (ramp_up_q) begin
                if (duty_q == DUTY_MAX) begin
                    ramp_up_d = 1'b0;
                    duty_d    = DUTY_MAX - DUTY_ONE;
                    chase_ev  = 1'b1;
                end else begin
                    duty_d = duty_q + DUTY_ONE;
                end
            end else begin
                if (duty_q == DUTY_MIN) begin
                    ramp_up_d = 1'b1;
                    duty_d    = DUTY_MIN + DUTY_ONE;
                    chase_ev  = 1'b1;
                end else begin
                    duty_d = duty_q - DUTY_ONE;
                end
            end
        end

        if (chase_ev) begin
            led_d = (st_q == ST_RUN_FWD) ? rot_left(led_q) : rot_right(led_q);
        end

        case (st_q)
            ST_IDLE: begin
                if (run_ev) begin
                    st_d      = ST_RUN_FWD;
                    led_d     = LED_FIRST;
                    duty_d    = DUTY_MIN;
                    ramp_up_d = 1'b1;
                end
            end
            ST_RUN_FWD: begin
                if (run_ev) begin
                    st_d        = ST_PAUSE;
                    saved_dir_d = DIR_FWD;
                end else if (dir_ev) begin
                    st_d = ST_RUN_REV;
                end
            end
            ST_RUN_REV: begin
                if (run_ev) begin
                    st_d        = ST_PAUSE;
                    saved_dir_d = DIR_REV;
                end else if (dir_ev) begin
                    st_d = ST_RUN_FWD;
                end
            end
            ST_PAUSE: begin
                if (run_ev) begin
                    st_d = (saved_dir_q == DIR_REV) ? ST_RUN_REV : ST_RUN_FWD;
                end else if (dir_ev) begin
                    saved_dir_d = (saved_dir_q == DIR_FWD) ? DIR_REV : DIR_FWD;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            st_q        <= ST_IDLE;
            led_q       <= '0;
            duty_q      <= DUTY_MIN;
            ramp_up_q   <= 1'b1;
            saved_dir_q <= DIR_FWD;
        end else begin
            presc       <= presc + PRESC_ONE;
            pwm_cnt     <= pwm_cnt + DUTY_ONE;
            st_q        <= st_d;
            led_q       <= led_d;
            duty_q      <= duty_d;
            ramp_up_q   <= ramp_up_d;
            saved_dir_q <= saved_dir_d;
        end
    end

endmodule

// File: tb/tb_led_chase_sequencer.sv
// Directed bench for led_chase_sequencer (DIV_W = 4, DEB_W = 3); honours DEBOUNCE_EN.
module tb_led_chase_sequencer;

`ifdef DEBOUNCE_EN
    localparam int LAT = 10;
    localparam int GAP = 12;
`else
    localparam int LAT = 3;
    localparam int GAP = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_dir = 1'b0;
    logic [3:0] led_drive;
    logic [3:0] led_onehot;
    logic       pwm_out;
    logic [5:0] duty;
    logic [1:0] state;
    logic       step_tick;

    int n_cmp = 0;
    int n_err = 0;

    led_chase_sequencer #(
        .DIV_W    (4),
        .DUTY_MIN (6'd0),
        .DUTY_MAX (6'd63),
        .DEB_W    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_run    (btn_run),
        .btn_dir    (btn_dir),
        .led_drive  (led_drive),
        .led_onehot (led_onehot),
        .pwm_out    (pwm_out),
        .duty       (duty),
        .state      (state),
        .step_tick  (step_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic r, input logic d);
        btn_run = r;
        btn_dir = d;
        repeat (LAT) tick();
        btn_run = 1'b0;
        btn_dir = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (!step_tick && guard < 40) begin
                tick();
                guard++;
            end
            n_cmp++;
            if (!step_tick) begin
                n_err++;
                $display("FAIL step_tick_timeout: got no strobe within %0d cycles, want one", guard);
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (state !== 2'd0)      begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (led_drive !== 4'h0)  begin n_err++; $display("FAIL rst_led_drive: got %b want 0000", led_drive); end
        n_cmp++; if (led_onehot !== 4'h0) begin n_err++; $display("FAIL rst_led_onehot: got %b want 0000", led_onehot); end
        n_cmp++; if (duty !== 6'd0)       begin n_err++; $display("FAIL rst_duty: got %0d want 0", duty); end
        n_cmp++; if (pwm_out !== 1'b0)    begin n_err++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
        n_cmp++; if (step_tick !== 1'b0)  begin n_err++; $display("FAIL rst_step_tick: got %b want 0", step_tick); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_run();
        wait_ticks(1);
        btn_run = 1'b1;
        repeat (LAT - 1) tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL run_early: got %0d want 0", state); end
        tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL run_state: got %0d want 1", state); end
        btn_run = 1'b0;
        repeat (GAP) tick();
        n_cmp++; if (led_onehot !== 4'b0001) begin n_err++; $display("FAIL run_led: got %b want 0001", led_onehot); end
        n_cmp++; if (duty !== 6'd0) begin n_err++; $display("FAIL run_duty0: got %0d want 0", duty); end
        wait_ticks(63);
        n_cmp++; if (duty !== 6'd63) begin n_err++; $display("FAIL ramp_top: got %0d want 63", duty); end
        n_cmp++; if (pwm_out !== 1'b1 || led_drive !== 4'b0001) begin
            n_err++; $display("FAIL duty_full_pwm: got pwm=%b drive=%b want 1/0001", pwm_out, led_drive); end
        wait_ticks(1);
        n_cmp++; if (duty !== 6'd62) begin n_err++; $display("FAIL ramp_turn: got %0d want 62", duty); end
        n_cmp++; if (led_onehot !== 4'b0010) begin n_err++; $display("FAIL chase_fwd: got %b want 0010", led_onehot); end
    endtask

    task automatic test_dir();
        press(1'b0, 1'b1);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL dir_state: got %0d want 2", state); end
        n_cmp++; if (duty !== 6'd62 || led_onehot !== 4'b0010) begin
            n_err++; $display("FAIL dir_keep: got duty=%0d led=%b want 62/0010", duty, led_onehot); end
        wait_ticks(62);
        n_cmp++; if (duty !== 6'd0 || led_onehot !== 4'b0010) begin
            n_err++; $display("FAIL ramp_bottom: got duty=%0d led=%b want 0/0010", duty, led_onehot); end
        wait_ticks(1);
        n_cmp++; if (duty !== 6'd1 || led_onehot !== 4'b0001) begin
            n_err++; $display("FAIL chase_rev1: got duty=%0d led=%b want 1/0001", duty, led_onehot); end
        wait_ticks(63);
        n_cmp++; if (duty !== 6'd62 || led_onehot !== 4'b1000) begin
            n_err++; $display("FAIL chase_rev2: got duty=%0d led=%b want 62/1000", duty, led_onehot); end
    endtask

    task automatic test_pause();
        int hi = 0;
        press(1'b0, 1'b1);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL back_fwd: got %0d want 1", state); end
        press(1'b1, 1'b0);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL pause_state: got %0d want 3", state); end
        press(1'b0, 1'b1);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL pause_dir_hold: got %0d want 3", state); end
        wait_ticks(100);
        n_cmp++; if (duty !== 6'd62 || led_onehot !== 4'b1000) begin
            n_err++; $display("FAIL pause_frozen: got duty=%0d led=%b want 62/1000", duty, led_onehot); end
        for (int i = 0; i < 64; i++) begin
            if (pwm_out) hi++;
            tick();
        end
        n_cmp++; if (hi != 63) begin n_err++; $display("FAIL pause_pwm: got %0d high cycles want 63", hi); end
        press(1'b1, 1'b0);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL resume_rev: got %0d want 2", state); end
    endtask

    task automatic test_back_to_back();
        press(1'b0, 1'b1);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL b2b_fwd: got %0d want 1", state); end
        press(1'b1, 1'b1);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL b2b_pause: got %0d want 3", state); end
        press(1'b1, 1'b0);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL b2b_saved_fwd: got %0d want 1", state); end
    endtask

    task automatic test_glitch();
`ifdef DEBOUNCE_EN
        btn_run = 1'b1;
        repeat (5) tick();
        btn_run = 1'b0;
        repeat (GAP) tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL glitch_ignored: got %0d want 1", state); end
        btn_run = 1'b1;
        repeat (9) tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL deb_early: got %0d want 1", state); end
        tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL deb_press: got %0d want 3", state); end
        btn_run = 1'b0;
        repeat (GAP) tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL deb_single: got %0d want 3", state); end
`else
        btn_run = 1'b1;
        repeat (3) tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL glitch_event: got %0d want 3", state); end
        repeat (2) tick();
        btn_run = 1'b0;
        repeat (GAP) tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL glitch_single: got %0d want 3", state); end
`endif
        press(1'b1, 1'b0);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL glitch_resume: got %0d want 1", state); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0 || led_onehot !== 4'h0 || led_drive !== 4'h0) begin
            n_err++; $display("FAIL midrst_state: got st=%0d led=%b drive=%b want 0/0000/0000", state, led_onehot, led_drive); end
        n_cmp++; if (duty !== 6'd0 || pwm_out !== 1'b0 || step_tick !== 1'b0) begin
            n_err++; $display("FAIL midrst_dp: got duty=%0d pwm=%b tick=%b want 0/0/0", duty, pwm_out, step_tick); end
        rst_n = 1'b1;
        press(1'b1, 1'b0);
        n_cmp++; if (state !== 2'd1 || led_onehot !== 4'b0001 || duty !== 6'd0) begin
            n_err++; $display("FAIL restart: got st=%0d led=%b duty=%0d want 1/0001/0", state, led_onehot, duty); end
    endtask

    initial begin
        #1;
        test_reset();
        test_run();
        test_dir();
        test_pause();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2000000 time units, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_chase_sequencer.md
Name: led_chase_sequencer

Overview:
- Controller that sequences the board's LED datapath: a PWM brightness ramp and a 4-LED one-hot chaser, both driven by button commands.
- Owns the prescaler, button conditioning, and run/pause/direction FSM.
- Advances the triangle duty ramp and rotates the chaser position at the ramp endpoints.
- Sits between the raw board buttons and the U8 LED header outputs in the top level.

Parameters:
- DIV_W, 22, prescaler width; step_tick period = 2^DIV_W clk cycles.
- DUTY_MIN, 6'd0, lower ramp endpoint.
- DUTY_MAX, 6'd63, upper ramp endpoint; must exceed DUTY_MIN.
- DEB_W, 16, debounce counter width; stable time = 2^DEB_W - 1 cycles. Used only with DEBOUNCE_EN.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- btn_run, input, 1, raw async run/pause button, active high.
- btn_dir, input, 1, raw async direction button, active high.
- led_drive, output, 4, led_onehot gated by pwm_out.
- led_onehot, output, 4, current chaser position.
- pwm_out, output, 1, PWM compare result.
- duty, output, 6, current duty value.
- state, output, 2, FSM state: IDLE=0, RUN_FWD=1, RUN_REV=2, PAUSE=3.
- step_tick, output, 1, one-cycle prescaler strobe.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, synchronous, active-low, sampled on posedge clk; no async reset paths.
- Reset values:
  - state = IDLE, led_onehot = 4'b0000, led_drive = 0, pwm_out = 0, duty = DUTY_MIN, step_tick = 0.
  - Prescaler = 0, pwm_cnt = 0, ramp_up = 1, saved_dir = FWD, synchronizers = 0.
  - Reset mid-run aborts immediately to these values.
- Prescaler: DIV_W-bit free-running counter. step_tick = 1 for exactly the cycle the counter == all ones; the counter wraps to 0.
- PWM: 6-bit pwm_cnt increments every clk and wraps 63 -> 0. pwm_out = (pwm_cnt <= duty) in RUN_FWD, RUN_REV and PAUSE; pwm_out is forced 0 in IDLE. duty = 63 gives pwm_out always 1.
- Button path: 2-FF synchronizer per button, then conditioning (see Optional Feature). Rising-edge detect on the conditioned level gives run_ev and dir_ev, one cycle each.
- Duty ramp: updates only on step_tick and only in RUN_FWD/RUN_REV.
  - ramp_up and duty < DUTY_MAX: duty + 1.
  - ramp_up and duty == DUTY_MAX: ramp_up <= 0, duty <= DUTY_MAX - 1, chase_ev.
  - Down direction is symmetric at DUTY_MIN.
- Chaser: on chase_ev, RUN_FWD rotates left (0001->0010->0100->1000->0001) and RUN_REV rotates right.
- FSM transitions are registered; the new state is visible the cycle after the event. run_ev has priority when run_ev and dir_ev occur in the same cycle; dir_ev is then dropped.
  - IDLE: on run_ev go to RUN_FWD; led_onehot <= 0001, duty <= DUTY_MIN, ramp_up <= 1. dir_ev is ignored.
  - RUN_FWD: on run_ev go to PAUSE with saved_dir <= FWD; on dir_ev go to RUN_REV. Position and duty are kept.
  - RUN_REV: symmetric to RUN_FWD (run_ev saves REV; dir_ev goes to RUN_FWD).
  - PAUSE: duty, led_onehot and ramp_up are frozen; PWM keeps running. dir_ev toggles saved_dir. run_ev resumes to RUN_FWD or RUN_REV per saved_dir.
- A step_tick coinciding with a state-change cycle is evaluated with the old state.
- Latency: raw button edge to state change is 3 clk cycles without debounce, and 3 + 2^DEB_W - 1 cycles with debounce.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined: the conditioned level follows the synchronized level only after it has differed continuously for 2^DEB_W - 1 cycles. The DEB_W-bit counter clears whenever the levels match; a glitch shorter than that time produces no event.
- Undefined: conditioned level = synchronized level; DEB_W is unused and no counter logic is generated.

Decomposition:
- Package led_seq_pkg: state encoding constants (ST_IDLE, ST_RUN_FWD, ST_RUN_REV, ST_PAUSE), DIR_FWD/DIR_REV, DUTY_W = 6, LED_N = 4.
- One sub-module: btn_conditioner (sync, optional debounce, rising-edge pulse); instantiated twice.
- FSM, ramp, chaser, prescaler and PWM stay in the top module.

Test Plan (DIV_W = 4, DEB_W = 3):
- Reset with rst_n = 0 over 3 clks -> state = 0, led_drive = 0, duty = 0, pwm_out = 0. Reset again mid-RUN -> same values on the next clk.
- Single run press in IDLE -> state = 1 three clks after the edge, led_onehot = 0001. After 63 step_ticks, duty = 63. The next tick gives duty = 62 and led_onehot = 0010.
- In RUN_FWD with led_onehot = 0010, press dir -> state = 2; at the next endpoint led_onehot = 0001, then 1000.
- Press run (PAUSE), press dir, run 100 step_ticks -> duty and led_onehot unchanged, pwm_out still toggling. Press run -> state = 2.
- run and dir edges in the same clk while in RUN_FWD -> state = 3 and saved_dir = FWD; the dir press is discarded.
- With DEBOUNCE_EN, a 5-cycle glitch on btn_run produces no state change, while a 10-cycle press produces exactly one run_ev. Without the macro, the 5-cycle glitch changes state.
